// File: rtl/ctrl_pipe_unit_pkg.sv
// ============================================================================
// Module      : ctrl_pipe_unit_pkg
// Description : Opcode, funct and ALU operation constants plus the ID/EX
//               control bundle shared by the pipelined control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pipe_unit_pkg;

    localparam int c_ALUOPW = 4;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;
    localparam logic [5:0] c_FN_MULT = 6'b011000;

    localparam logic [c_ALUOPW-1:0] c_ALU_AND = 4'b0000;
    localparam logic [c_ALUOPW-1:0] c_ALU_OR  = 4'b0001;
    localparam logic [c_ALUOPW-1:0] c_ALU_ADD = 4'b0010;
    localparam logic [c_ALUOPW-1:0] c_ALU_SUB = 4'b0110;
    localparam logic [c_ALUOPW-1:0] c_ALU_SLT = 4'b0111;
    localparam logic [c_ALUOPW-1:0] c_ALU_MUL = 4'b1000;

    typedef struct packed {
        logic                branch_eq;
        logic                branch_ne;
        logic                jump;
        logic                memread;
        logic                memwrite;
        logic                memtoreg;
        logic                regdst;
        logic                regwrite;
        logic                alusrc;
        logic [c_ALUOPW-1:0] aluop;
    } ctrl_t;

    // Control bundle carried by a bubble: nothing asserted, ALU defaults to add.
    function automatic ctrl_t bubble_ctrl();
        ctrl_t v_c;
        v_c       = '0;
        v_c.aluop = c_ALU_ADD;
        return v_c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_pipe_unit_decode.sv
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational opcode/funct decoder producing the control
//               bundle, illegal flag, MULT marker and rt-as-source marker.
//               CTRL_IMM_LOGIC_EN enables ANDI/ORI/SLTI decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode
    import ctrl_pipe_unit_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic [OPW-1:0] i_opcode,
    input  logic [FNW-1:0] i_funct,
    output ctrl_t          o_ctrl,
    output logic           o_illegal,
    output logic           o_is_mult,
    output logic           o_uses_rt
);

    always_comb begin
        o_ctrl    = bubble_ctrl();
        o_illegal = 1'b0;
        o_is_mult = 1'b0;
        o_uses_rt = 1'b0;
        case (i_opcode)
            c_OP_LW: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.memread  = 1'b1;
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            c_OP_SW: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.memwrite = 1'b1;
                o_uses_rt       = 1'b1;
            end
            c_OP_BEQ: begin
                o_ctrl.branch_eq = 1'b1;
                o_ctrl.aluop     = c_ALU_SUB;
                o_uses_rt        = 1'b1;
            end
            c_OP_BNE: begin
                o_ctrl.branch_ne = 1'b1;
                o_ctrl.aluop     = c_ALU_SUB;
                o_uses_rt        = 1'b1;
            end
            c_OP_ADDI: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            c_OP_J: begin
                o_ctrl.jump = 1'b1;
            end
`ifdef CTRL_IMM_LOGIC_EN
            c_OP_ANDI: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.aluop    = c_ALU_AND;
            end
            c_OP_ORI: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.aluop    = c_ALU_OR;
            end
            c_OP_SLTI: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.aluop    = c_ALU_SLT;
            end
`endif
            c_OP_RTYPE: begin
                o_uses_rt       = 1'b1;
                o_ctrl.regdst   = 1'b1;
                o_ctrl.regwrite = 1'b1;
                case (i_funct)
                    c_FN_ADD: o_ctrl.aluop = c_ALU_ADD;
                    c_FN_SUB: o_ctrl.aluop = c_ALU_SUB;
                    c_FN_AND: o_ctrl.aluop = c_ALU_AND;
                    c_FN_OR:  o_ctrl.aluop = c_ALU_OR;
                    c_FN_SLT: o_ctrl.aluop = c_ALU_SLT;
                    c_FN_MULT: begin
                        o_ctrl.aluop    = c_ALU_MUL;
                        o_ctrl.regwrite = 1'b0;
                        o_is_mult       = 1'b1;
                    end
                    default: begin
                        o_ctrl    = bubble_ctrl();
                        o_illegal = 1'b1;
                    end
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ctrl_pipe_unit.sv
// ============================================================================
// Module      : ctrl_pipe_unit
// Description : ID-stage control unit: registered ID/EX control bundle,
//               load-use hazard detection and multi-cycle MULT stall FSM.
//               CTRL_IMM_LOGIC_EN enables ANDI/ORI/SLTI decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipe_unit
    import ctrl_pipe_unit_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int FNW     = 6,
    parameter int REGW    = 5,
    parameter int ALUOPW  = 4,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [OPW-1:0]    opcode,
    input  logic [FNW-1:0]    funct,
    input  logic [REGW-1:0]   rs,
    input  logic [REGW-1:0]   rt,
    input  logic              stall_in,
    input  logic              flush,
    output logic              ex_valid,
    output logic              branch_eq,
    output logic              branch_ne,
    output logic              jump,
    output logic              memread,
    output logic              memwrite,
    output logic              memtoreg,
    output logic              regdst,
    output logic              regwrite,
    output logic              alusrc,
    output logic [ALUOPW-1:0] aluop,
    output logic [REGW-1:0]   ex_rt,
    output logic              illegal,
    output logic              illegal_seen,
    output logic              mul_busy,
    output logic              stall_out
);

    localparam int                c_CNTW      = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam logic [c_CNTW-1:0] c_CNT_LOAD  = c_CNTW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
    localparam bit                c_MUL_MULTI = (MUL_LAT > 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    ctrl_t             w_dec_ctrl;
    logic              w_dec_illegal;
    logic              w_dec_is_mult;
    logic              w_dec_uses_rt;
    logic              w_hazard;
    logic              w_load_bubble;
    logic              w_load_id;

    logic [0:0]        r_state,        w_state_nxt;
    logic [c_CNTW-1:0] r_cnt,          w_cnt_nxt;
    ctrl_t             r_ctrl,         w_ctrl_nxt;
    logic              r_ex_valid,     w_ex_valid_nxt;
    logic [REGW-1:0]   r_ex_rt,        w_ex_rt_nxt;
    logic              r_illegal,      w_illegal_nxt;
    logic              r_illegal_seen, w_illegal_seen_nxt;

    ctrl_decode #(
        .OPW (OPW),
        .FNW (FNW)
    ) u_decode (
        .i_opcode  (opcode),
        .i_funct   (funct),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal),
        .o_is_mult (w_dec_is_mult),
        .o_uses_rt (w_dec_uses_rt)
    );

    assign w_hazard = r_ex_valid && r_ctrl.memread && (r_ex_rt != '0) &&
                      ((r_ex_rt == rs) || ((r_ex_rt == rt) && w_dec_uses_rt));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ctrl_nxt     = r_ctrl;
        w_ex_valid_nxt = r_ex_valid;
        w_ex_rt_nxt    = r_ex_rt;
        w_illegal_nxt  = r_illegal;
        w_load_bubble  = 1'b0;
        w_load_id      = 1'b0;

        if (flush) begin
            w_load_bubble = 1'b1;
            w_state_nxt   = c_ST_IDLE;
            w_cnt_nxt     = '0;
        end else begin
            // The MULT latency is wall-clock time, so it keeps counting under stall_in.
            if ((r_state == c_ST_BUSY) && (r_cnt != '0)) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
            if (stall_in) begin
                w_load_bubble = 1'b0;
            end else if (w_hazard || (r_state == c_ST_BUSY)) begin
                w_load_bubble = 1'b1;
                if ((r_state == c_ST_BUSY) && (r_cnt == '0)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end else if (!in_valid) begin
                w_load_bubble = 1'b1;
            end else begin
                w_load_id = 1'b1;
                if (w_dec_is_mult && c_MUL_MULTI) begin
                    w_state_nxt = c_ST_BUSY;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
        end

        if (w_load_bubble) begin
            w_ctrl_nxt     = bubble_ctrl();
            w_ex_valid_nxt = 1'b0;
            w_ex_rt_nxt    = '0;
            w_illegal_nxt  = 1'b0;
        end else if (w_load_id) begin
            w_ctrl_nxt     = w_dec_ctrl;
            w_ex_valid_nxt = 1'b1;
            w_ex_rt_nxt    = rt;
            w_illegal_nxt  = w_dec_illegal;
        end

        w_illegal_seen_nxt = r_illegal_seen | w_illegal_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_ctrl         <= bubble_ctrl();
            r_ex_valid     <= 1'b0;
            r_ex_rt        <= '0;
            r_illegal      <= 1'b0;
            r_illegal_seen <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_ctrl         <= w_ctrl_nxt;
            r_ex_valid     <= w_ex_valid_nxt;
            r_ex_rt        <= w_ex_rt_nxt;
            r_illegal      <= w_illegal_nxt;
            r_illegal_seen <= w_illegal_seen_nxt;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign branch_eq    = r_ctrl.branch_eq;
    assign branch_ne    = r_ctrl.branch_ne;
    assign jump         = r_ctrl.jump;
    assign memread      = r_ctrl.memread;
    assign memwrite     = r_ctrl.memwrite;
    assign memtoreg     = r_ctrl.memtoreg;
    assign regdst       = r_ctrl.regdst;
    assign regwrite     = r_ctrl.regwrite;
    assign alusrc       = r_ctrl.alusrc;
    assign aluop        = r_ctrl.aluop;
    assign ex_rt        = r_ex_rt;
    assign illegal      = r_illegal;
    assign illegal_seen = r_illegal_seen;
    assign mul_busy     = (r_state == c_ST_BUSY);
    assign stall_out    = stall_in | w_hazard | mul_busy;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe_unit.sv
// ============================================================================
// Module      : tb_ctrl_pipe_unit
// Description : Self-checking bench for ctrl_pipe_unit (MUL_LAT = 4);
//               expectations follow CTRL_IMM_LOGIC_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipe_unit;
    import ctrl_pipe_unit_pkg::*;

    localparam logic [8:0] c_B_BEQ = 9'b100000000;
    localparam logic [8:0] c_B_BNE = 9'b010000000;
    localparam logic [8:0] c_B_J   = 9'b001000000;
    localparam logic [8:0] c_B_MR  = 9'b000100000;
    localparam logic [8:0] c_B_MW  = 9'b000010000;
    localparam logic [8:0] c_B_M2R = 9'b000001000;
    localparam logic [8:0] c_B_RD  = 9'b000000100;
    localparam logic [8:0] c_B_RW  = 9'b000000010;
    localparam logic [8:0] c_B_AS  = 9'b000000001;

    localparam logic [5:0] c_RT = 6'b000000;

    typedef struct packed {
        logic       ex_valid;
        logic [8:0] ctl;
        logic [3:0] aluop;
        logic       illegal;
    } exp_t;

    typedef struct {
        string      name;
        logic       vld;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        exp_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       stall_in;
    logic       flush;
    logic       ex_valid, branch_eq, branch_ne, jump, memread, memwrite;
    logic       memtoreg, regdst, regwrite, alusrc;
    logic [3:0] aluop;
    logic [4:0] ex_rt;
    logic       illegal, illegal_seen, mul_busy, stall_out;

    exp_t       r_exp_q[$];
    vec_t       r_tbl[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [14:0] w_act;

    assign w_act = {ex_valid, branch_eq, branch_ne, jump, memread, memwrite,
                    memtoreg, regdst, regwrite, alusrc, aluop, illegal};

    ctrl_pipe_unit #(
        .OPW(6), .FNW(6), .REGW(5), .ALUOPW(4), .MUL_LAT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
        .funct(funct), .rs(rs), .rt(rt), .stall_in(stall_in), .flush(flush),
        .ex_valid(ex_valid), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .jump(jump), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrc(alusrc), .aluop(aluop), .ex_rt(ex_rt), .illegal(illegal),
        .illegal_seen(illegal_seen), .mul_busy(mul_busy), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input logic [8:0] ctl,
                                input logic [3:0] op, input logic ill);
        return {v, ctl, op, ill};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] s, input logic [4:0] t);
        in_valid = v; opcode = op; funct = fn; rs = s; rt = t;
    endtask

    task automatic tick_check(input string nm);
        exp_t v_e;
        @(posedge clk);
        #1;
        if (r_exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %0h", nm, w_act);
        end else begin
            v_e = r_exp_q.pop_front();
            chk(nm, 32'(w_act), 32'(v_e));
        end
    endtask

    task automatic add_vec(input string nm, input logic v, input logic [5:0] op,
                           input logic [5:0] fn, input logic [4:0] t, input exp_t e);
        vec_t v_r;
        v_r.name = nm; v_r.vld = v; v_r.op = op; v_r.fn = fn; v_r.rt = t; v_r.exp = e;
        r_tbl.push_back(v_r);
    endtask

    initial begin
        exp_t v_bub;
        exp_t v_add;
        exp_t v_lw;
        exp_t v_beq;
        exp_t v_mul;
        exp_t v_addi;
        exp_t v_imm_and, v_imm_or, v_imm_slt;

        v_bub  = mk(1'b0, 9'd0, c_ALU_ADD, 1'b0);
        v_add  = mk(1'b1, c_B_RD | c_B_RW, c_ALU_ADD, 1'b0);
        v_lw   = mk(1'b1, c_B_AS | c_B_MR | c_B_M2R | c_B_RW, c_ALU_ADD, 1'b0);
        v_beq  = mk(1'b1, c_B_BEQ, c_ALU_SUB, 1'b0);
        v_mul  = mk(1'b1, c_B_RD, c_ALU_MUL, 1'b0);
        v_addi = mk(1'b1, c_B_AS | c_B_RW, c_ALU_ADD, 1'b0);
`ifdef CTRL_IMM_LOGIC_EN
        v_imm_and = mk(1'b1, c_B_AS | c_B_RW, c_ALU_AND, 1'b0);
        v_imm_or  = mk(1'b1, c_B_AS | c_B_RW, c_ALU_OR,  1'b0);
        v_imm_slt = mk(1'b1, c_B_AS | c_B_RW, c_ALU_SLT, 1'b0);
`else
        v_imm_and = mk(1'b1, 9'd0, c_ALU_ADD, 1'b1);
        v_imm_or  = v_imm_and;
        v_imm_slt = v_imm_and;
`endif

        add_vec("addi",   1'b1, 6'b001000, 6'd0,      5'd2, v_addi);
        add_vec("lw",     1'b1, 6'b100011, 6'd0,      5'd3, v_lw);
        add_vec("sw",     1'b1, 6'b101011, 6'd0,      5'd2, mk(1'b1, c_B_AS | c_B_MW, c_ALU_ADD, 1'b0));
        add_vec("beq",    1'b1, 6'b000100, 6'd0,      5'd2, v_beq);
        add_vec("bne",    1'b1, 6'b000101, 6'd0,      5'd2, mk(1'b1, c_B_BNE, c_ALU_SUB, 1'b0));
        add_vec("j",      1'b1, 6'b000010, 6'd0,      5'd2, mk(1'b1, c_B_J, c_ALU_ADD, 1'b0));
        add_vec("r_add",  1'b1, c_RT,      6'b100000, 5'd2, v_add);
        add_vec("r_sub",  1'b1, c_RT,      6'b100010, 5'd2, mk(1'b1, c_B_RD | c_B_RW, c_ALU_SUB, 1'b0));
        add_vec("r_and",  1'b1, c_RT,      6'b100100, 5'd2, mk(1'b1, c_B_RD | c_B_RW, c_ALU_AND, 1'b0));
        add_vec("r_or",   1'b1, c_RT,      6'b100101, 5'd2, mk(1'b1, c_B_RD | c_B_RW, c_ALU_OR, 1'b0));
        add_vec("r_slt",  1'b1, c_RT,      6'b101010, 5'd2, mk(1'b1, c_B_RD | c_B_RW, c_ALU_SLT, 1'b0));
        add_vec("r_badfn",1'b1, c_RT,      6'b000001, 5'd2, mk(1'b1, 9'd0, c_ALU_ADD, 1'b1));
        add_vec("invalid",1'b0, 6'b001000, 6'd0,      5'd2, v_bub);
        add_vec("andi",   1'b1, 6'b001100, 6'd0,      5'd2, v_imm_and);
        add_vec("ori",    1'b1, 6'b001101, 6'd0,      5'd2, v_imm_or);
        add_vec("slti",   1'b1, 6'b001010, 6'd0,      5'd2, v_imm_slt);

        // Reset state
        rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bundle", 32'(w_act), 32'(v_bub));
        chk("rst_ex_rt", 32'(ex_rt), 32'd0);
        chk("rst_busy", 32'(mul_busy), 32'd0);
        chk("rst_seen", 32'(illegal_seen), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        rst_n = 1'b1;

        // Decode table
        for (int i = 0; i < r_tbl.size(); i++) begin
            drive(r_tbl[i].vld, r_tbl[i].op, r_tbl[i].fn, 5'd1, r_tbl[i].rt);
            r_exp_q.push_back(r_tbl[i].exp);
            tick_check(r_tbl[i].name);
            chk({r_tbl[i].name, "_stall"}, 32'(stall_out), 32'd0);
        end

        // Load-use on rs
        drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd5);
        r_exp_q.push_back(v_lw); tick_check("lu_lw");
        chk("lu_ex_rt", 32'(ex_rt), 32'd5);
        drive(1'b1, c_RT, 6'b100000, 5'd5, 5'd2);
        #1 chk("lu_stall", 32'(stall_out), 32'd1);
        r_exp_q.push_back(v_bub); tick_check("lu_bubble");
        chk("lu_unstall", 32'(stall_out), 32'd0);
        r_exp_q.push_back(v_add); tick_check("lu_issue");

        // Load to $0 never stalls
        drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd0);
        r_exp_q.push_back(v_lw); tick_check("lu0_lw");
        drive(1'b1, c_RT, 6'b100000, 5'd0, 5'd0);
        #1 chk("lu0_stall", 32'(stall_out), 32'd0);
        r_exp_q.push_back(v_add); tick_check("lu0_issue");

        // rt match: ADDI does not read rt, BEQ does
        drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd7);
        r_exp_q.push_back(v_lw); tick_check("lurt_lw");
        drive(1'b1, 6'b001000, 6'd0, 5'd1, 5'd7);
        #1 chk("lurt_addi_stall", 32'(stall_out), 32'd0);
        drive(1'b1, 6'b000100, 6'd0, 5'd1, 5'd7);
        #1 chk("lurt_beq_stall", 32'(stall_out), 32'd1);
        r_exp_q.push_back(v_bub); tick_check("lurt_bubble");
        r_exp_q.push_back(v_beq); tick_check("lurt_issue");

        // MULT, full latency
        drive(1'b1, c_RT, 6'b011000, 5'd1, 5'd2);
        r_exp_q.push_back(v_mul); tick_check("mul_issue");
        chk("mul_busy0", 32'(mul_busy), 32'd1);
        chk("mul_stall0", 32'(stall_out), 32'd1);
        drive(1'b1, c_RT, 6'b100000, 5'd1, 5'd2);
        for (int c = 1; c <= 3; c++) begin
            r_exp_q.push_back(v_bub); tick_check("mul_bubble");
            chk("mul_busy_n", 32'(mul_busy), (c < 3) ? 32'd1 : 32'd0);
        end
        chk("mul_release", 32'(stall_out), 32'd0);
        r_exp_q.push_back(v_add); tick_check("mul_next");

        // MULT aborted by flush on cycle 2
        drive(1'b1, c_RT, 6'b011000, 5'd1, 5'd2);
        r_exp_q.push_back(v_mul); tick_check("mulf_issue");
        drive(1'b1, c_RT, 6'b100000, 5'd1, 5'd2);
        r_exp_q.push_back(v_bub); tick_check("mulf_bubble");
        chk("mulf_busy", 32'(mul_busy), 32'd1);
        flush = 1'b1;
        r_exp_q.push_back(v_bub); tick_check("mulf_flush");
        chk("mulf_idle", 32'(mul_busy), 32'd0);
        flush = 1'b0;
        r_exp_q.push_back(v_add); tick_check("mulf_next");

        // MULT counter keeps running under stall_in
        drive(1'b1, c_RT, 6'b011000, 5'd1, 5'd2);
        r_exp_q.push_back(v_mul); tick_check("muls_issue");
        drive(1'b1, c_RT, 6'b100000, 5'd1, 5'd2);
        stall_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            r_exp_q.push_back(v_mul); tick_check("muls_hold");
        end
        chk("muls_busy", 32'(mul_busy), 32'd1);
        stall_in = 1'b0;
        r_exp_q.push_back(v_bub); tick_check("muls_bubble");
        chk("muls_idle", 32'(mul_busy), 32'd0);
        r_exp_q.push_back(v_add); tick_check("muls_next");

        // Downstream stall holds BEQ, then flush beats stall_in
        drive(1'b1, 6'b000100, 6'd0, 5'd1, 5'd2);
        r_exp_q.push_back(v_beq); tick_check("st_beq");
        drive(1'b1, 6'b001000, 6'd0, 5'd1, 5'd2);
        stall_in = 1'b1;
        #1 chk("st_stall_out", 32'(stall_out), 32'd1);
        r_exp_q.push_back(v_beq); tick_check("st_hold1");
        r_exp_q.push_back(v_beq); tick_check("st_hold2");
        flush = 1'b1;
        r_exp_q.push_back(v_bub); tick_check("st_flush");
        flush = 1'b0; stall_in = 1'b0;
        r_exp_q.push_back(v_addi); tick_check("st_resume");

        // Sticky illegal flag
        rst_n = 1'b0;
        #1 chk("ill_pre_seen", 32'(illegal_seen), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 6'b111111, 6'd0, 5'd1, 5'd2);
        r_exp_q.push_back(mk(1'b1, 9'd0, c_ALU_ADD, 1'b1)); tick_check("ill_op");
        chk("ill_seen", 32'(illegal_seen), 32'd1);
        drive(1'b1, 6'b001000, 6'd0, 5'd1, 5'd2);
        r_exp_q.push_back(v_addi); tick_check("ill_after");
        chk("ill_sticky", 32'(illegal_seen), 32'd1);
        rst_n = 1'b0;
        #1 chk("ill_cleared", 32'(illegal_seen), 32'd0);
        chk("ill_rst_bundle", 32'(w_act), 32'(v_bub));
        rst_n = 1'b1;

        if (r_exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", r_exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
